// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the multiplier issue/write-back
//               controller: FSM state type, default widths, latency bounds
//               and the width of the settle-latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } state_t;

    // Default operand/result and register-file address widths
    localparam int c_DATA_W_DEF  = 8;
    localparam int c_ADDR_W_DEF  = 3;

    // Array settle time in clock cycles, and its legal range
    localparam int c_LATENCY_DEF = 2;
    localparam int c_LATENCY_MIN = 1;
    localparam int c_LATENCY_MAX = 15;

    // Latency counter width, sized to hold c_LATENCY_MAX - 1
    localparam int c_CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/mult_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : mult_lat_counter
// Description : Loadable down-counter that times the multiplier settle
//               window. Load has priority over enable; the count saturates
//               at zero.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               i_load     - load i_load_val into the counter
//               i_en       - decrement enable
//               i_load_val - value to load
//               o_zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module mult_lat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue
// Description : Issue and write-back controller wrapped around the external
//               combinational array multiplier. Captures operands and the
//               destination register on START, holds them on the array
//               inputs for LATENCY cycles while stalling the PC, then issues
//               a one-cycle register-file write of the low DATA_W product
//               bits. START while an operation is in flight is rejected and
//               flagged on OVERRUN.
// Ports       : CLK, RESET          - clock, synchronous active-high reset
//               START               - MUL issue strobe
//               OPERAND1/OPERAND2   - multiplicand / multiplier from reg file
//               DEST_ADDR           - destination register
//               MULT_OUT            - product from the array
//               MCAND/MPLIER        - registered operands to the array
//               BUSY                - PC stall request
//               WB_VALID/DATA/ADDR  - register-file write port
//               OVERRUN             - pulse after a rejected START
// Revision    : 1.0 - initial release
// ============================================================================
module mult_issue
    import mult_pkg::*;
#(
    parameter int LATENCY = c_LATENCY_DEF,
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int ADDR_W  = c_ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] OPERAND1,
    input  logic [DATA_W-1:0] OPERAND2,
    input  logic [ADDR_W-1:0] DEST_ADDR,
    input  logic [DATA_W-1:0] MULT_OUT,
    output logic [DATA_W-1:0] MCAND,
    output logic [DATA_W-1:0] MPLIER,
    output logic              BUSY,
    output logic              WB_VALID,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic              OVERRUN
);

    // The counter is loaded with LATENCY-1 so that WAIT, which ends on the
    // cycle the counter reads zero, lasts exactly LATENCY cycles.
    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_reject;
    logic                w_capture;
    logic                w_cnt_en;
    logic                w_cnt_zero;

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [ADDR_W-1:0]   r_dest;
    logic                r_busy;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic                r_overrun;

    mult_lat_counter #(
        .WIDTH      (c_CNT_W)
    ) u_lat_counter (
        .clk        (CLK),
        .rst        (RESET),
        .i_load     (w_accept),
        .i_en       (w_cnt_en),
        .i_load_val (c_LOAD_VAL),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_capture    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_accept     = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_reject = START;
                w_cnt_en = ~w_cnt_zero;
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = WB;
                end
            end
            WB: begin
                // A START in the write-back cycle issues immediately so
                // back-to-back MULs lose no cycle.
                if (START) begin
                    w_accept     = 1'b1;
                    w_state_next = WAIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_dest     <= '0;
            r_busy     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_addr  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= OPERAND1;
                r_mplier <= OPERAND2;
                r_dest   <= DEST_ADDR;
            end
            if (w_capture) begin
                r_wb_data <= MULT_OUT;
                r_wb_addr <= r_dest;
            end
            r_busy     <= (w_state_next == WAIT);
            r_wb_valid <= w_capture;
            r_overrun  <= w_reject;
        end
    end

    assign MCAND    = r_mcand;
    assign MPLIER   = r_mplier;
    assign BUSY     = r_busy;
    assign WB_VALID = r_wb_valid;
    assign WB_DATA  = r_wb_data;
    assign WB_ADDR  = r_wb_addr;
    assign OVERRUN  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue
// Description : Directed self-checking bench for mult_issue. Two instances:
//               LATENCY=2 (main) and LATENCY=1. The external array is
//               modelled as the truncated product of the registered operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LATENCY=2 instance signals
    logic       start;
    logic [7:0] op1, op2, mult_out, mcand, mplier, wb_data;
    logic [2:0] dest, wb_addr;
    logic       busy, wb_valid, overrun;

    // LATENCY=1 instance signals
    logic       start1;
    logic [7:0] op1_1, op2_1, mult_out1, mcand1, mplier1, wb_data1;
    logic [2:0] dest1, wb_addr1;
    logic       busy1, wb_valid1, overrun1;

    // Array model: low 8 bits of the unsigned product
    assign mult_out  = mcand * mplier;
    assign mult_out1 = mcand1 * mplier1;

    mult_issue #(.LATENCY(2), .DATA_W(8), .ADDR_W(3)) dut (
        .CLK(clk), .RESET(rst), .START(start),
        .OPERAND1(op1), .OPERAND2(op2), .DEST_ADDR(dest),
        .MULT_OUT(mult_out), .MCAND(mcand), .MPLIER(mplier),
        .BUSY(busy), .WB_VALID(wb_valid), .WB_DATA(wb_data),
        .WB_ADDR(wb_addr), .OVERRUN(overrun)
    );

    mult_issue #(.LATENCY(1), .DATA_W(8), .ADDR_W(3)) dut_l1 (
        .CLK(clk), .RESET(rst), .START(start1),
        .OPERAND1(op1_1), .OPERAND2(op2_1), .DEST_ADDR(dest1),
        .MULT_OUT(mult_out1), .MCAND(mcand1), .MPLIER(mplier1),
        .BUSY(busy1), .WB_VALID(wb_valid1), .WB_DATA(wb_data1),
        .WB_ADDR(wb_addr1), .OVERRUN(overrun1)
    );

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one START on the main instance; returns just after edge k
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        op1 = a; op2 = b; dest = d; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({mcand, mplier, busy, wb_valid, wb_data, wb_addr, overrun} !== 30'd0) begin
            errors++;
            $display("FAIL reset_main: got mcand=%h mplier=%h busy=%b wbv=%b wbd=%h wba=%h ovr=%b, want all 0",
                     mcand, mplier, busy, wb_valid, wb_data, wb_addr, overrun);
        end
        checks++;
        if ({mcand1, mplier1, busy1, wb_valid1, wb_data1, wb_addr1, overrun1} !== 30'd0) begin
            errors++;
            $display("FAIL reset_l1: got mcand=%h mplier=%h busy=%b wbv=%b wbd=%h wba=%h ovr=%b, want all 0",
                     mcand1, mplier1, busy1, wb_valid1, wb_data1, wb_addr1, overrun1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        issue(8'h05, 8'h07, 3'd3);                     // edge k
        checks++;
        if ({busy, wb_valid, mcand, mplier} !== {1'b1, 1'b0, 8'h05, 8'h07}) begin
            errors++;
            $display("FAIL basic_k: got busy=%b wbv=%b mcand=%h mplier=%h, want 1 0 05 07",
                     busy, wb_valid, mcand, mplier);
        end
        step();                                        // k+1
        checks++;
        if ({busy, wb_valid} !== 2'b10) begin
            errors++;
            $display("FAIL basic_k1: got busy=%b wbv=%b, want 1 0", busy, wb_valid);
        end
        step();                                        // k+2
        checks++;
        if ({busy, wb_valid, wb_data, wb_addr} !== {1'b0, 1'b1, 8'h23, 3'd3}) begin
            errors++;
            $display("FAIL basic_wb: got busy=%b wbv=%b wbd=%h wba=%0d, want 0 1 23 3",
                     busy, wb_valid, wb_data, wb_addr);
        end
        step();                                        // k+3
        checks++;
        if ({busy, wb_valid, mcand, mplier} !== {1'b0, 1'b0, 8'h05, 8'h07}) begin
            errors++;
            $display("FAIL basic_after: got busy=%b wbv=%b mcand=%h mplier=%h, want 0 0 05 07",
                     busy, wb_valid, mcand, mplier);
        end
    endtask

    task automatic test_truncation();
        issue(8'h10, 8'h11, 3'd5);
        step();
        step();
        checks++;
        if ({wb_valid, wb_data, wb_addr} !== {1'b1, 8'h10, 3'd5}) begin
            errors++;
            $display("FAIL trunc_wb: got wbv=%b wbd=%h wba=%0d, want 1 10 5", wb_valid, wb_data, wb_addr);
        end
        step();
    endtask

    task automatic test_overrun();
        int n_wb;
        issue(8'h05, 8'h07, 3'd3);                     // edge k, now in WAIT
        op1 = 8'hFF; op2 = 8'hFF; dest = 3'd6; start = 1'b1;
        step();                                        // k+1: rejected START
        start = 1'b0;
        checks++;
        if ({overrun, busy, mcand, mplier} !== {1'b1, 1'b1, 8'h05, 8'h07}) begin
            errors++;
            $display("FAIL ovr_pulse: got ovr=%b busy=%b mcand=%h mplier=%h, want 1 1 05 07",
                     overrun, busy, mcand, mplier);
        end
        step();                                        // k+2
        checks++;
        if ({overrun, wb_valid, wb_data, wb_addr} !== {1'b0, 1'b1, 8'h23, 3'd3}) begin
            errors++;
            $display("FAIL ovr_wb: got ovr=%b wbv=%b wbd=%h wba=%0d, want 0 1 23 3",
                     overrun, wb_valid, wb_data, wb_addr);
        end
        n_wb = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wb_valid === 1'b1 || overrun === 1'b1) n_wb++;
        end
        checks++;
        if (n_wb !== 0) begin
            errors++;
            $display("FAIL ovr_no_second_wb: got %0d extra wb/overrun cycles, want 0", n_wb);
        end
    endtask

    task automatic test_back_to_back();
        issue(8'h02, 8'h03, 3'd1);                     // edge k
        step();                                        // k+1
        step();                                        // k+2: WB of first
        checks++;
        if ({busy, wb_valid, wb_data, wb_addr} !== {1'b0, 1'b1, 8'h06, 3'd1}) begin
            errors++;
            $display("FAIL b2b_wb1: got busy=%b wbv=%b wbd=%h wba=%0d, want 0 1 06 1",
                     busy, wb_valid, wb_data, wb_addr);
        end
        issue(8'h04, 8'h04, 3'd2);                     // k+3: START in WB cycle
        checks++;
        if ({busy, wb_valid, mcand, mplier} !== {1'b1, 1'b0, 8'h04, 8'h04}) begin
            errors++;
            $display("FAIL b2b_reissue: got busy=%b wbv=%b mcand=%h mplier=%h, want 1 0 04 04",
                     busy, wb_valid, mcand, mplier);
        end
        step();                                        // k+4
        checks++;
        if ({busy, wb_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_wait: got busy=%b wbv=%b, want 1 0", busy, wb_valid);
        end
        step();                                        // k+5: WB of second
        checks++;
        if ({busy, wb_valid, wb_data, wb_addr} !== {1'b0, 1'b1, 8'h10, 3'd2}) begin
            errors++;
            $display("FAIL b2b_wb2: got busy=%b wbv=%b wbd=%h wba=%0d, want 0 1 10 2",
                     busy, wb_valid, wb_data, wb_addr);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int n_act;
        issue(8'h05, 8'h07, 3'd4);                     // edge k, in WAIT
        rst = 1'b1;
        step();                                        // k+1: reset applied
        rst = 1'b0;
        checks++;
        if ({mcand, mplier, busy, wb_valid, wb_data, wb_addr, overrun} !== 30'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got mcand=%h mplier=%h busy=%b wbv=%b wbd=%h wba=%h ovr=%b, want all 0",
                     mcand, mplier, busy, wb_valid, wb_data, wb_addr, overrun);
        end
        n_act = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wb_valid === 1'b1 || busy === 1'b1) n_act++;
        end
        checks++;
        if (n_act !== 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d busy/wb cycles after reset, want 0", n_act);
        end
    endtask

    task automatic test_latency1();
        op1_1 = 8'h09; op2_1 = 8'h09; dest1 = 3'd7; start1 = 1'b1;
        step();                                        // edge k
        start1 = 1'b0;
        checks++;
        if ({busy1, wb_valid1} !== 2'b10) begin
            errors++;
            $display("FAIL lat1_k: got busy=%b wbv=%b, want 1 0", busy1, wb_valid1);
        end
        step();                                        // k+1
        checks++;
        if ({busy1, wb_valid1, wb_data1, wb_addr1} !== {1'b0, 1'b1, 8'h51, 3'd7}) begin
            errors++;
            $display("FAIL lat1_wb: got busy=%b wbv=%b wbd=%h wba=%0d, want 0 1 51 7",
                     busy1, wb_valid1, wb_data1, wb_addr1);
        end
        step();                                        // k+2
        checks++;
        if ({busy1, wb_valid1} !== 2'b00) begin
            errors++;
            $display("FAIL lat1_after: got busy=%b wbv=%b, want 0 0", busy1, wb_valid1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; op1 = '0; op2 = '0; dest = '0;
        start1 = 1'b0; op1_1 = '0; op2_1 = '0; dest1 = '0;
        test_reset();
        test_basic();
        test_truncation();
        test_overrun();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_issue.md
# mult_issue

Sequential issue and write-back controller for the 8-bit array multiplier in the single-cycle CPU datapath. It captures the operands and destination register when a MUL instruction is decoded and holds them stable on the multiplier inputs while the combinational array settles. It stalls the PC for a fixed number of cycles, then presents the 8-bit product to the register file as a one-cycle write-back request. It sits between instruction decode and register-file read (upstream) and the register-file write port (downstream), wrapped around the multiplier array.

## Interface
Parameters:
- LATENCY, default 2: clock cycles allowed for the array to settle, legal range 1–15.
- DATA_W, default 8: operand and result width.
- ADDR_W, default 3: register-file address width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset; sampled on the CLK rising edge.
- START  in  1  MUL issue strobe from the control unit; one cycle wide.
- OPERAND1  in  DATA_W  multiplicand, from register-file read port 1.
- OPERAND2  in  DATA_W  multiplier, from register-file read port 2.
- DEST_ADDR  in  ADDR_W  destination register.
- MULT_OUT  in  DATA_W  product returned by the multiplier array.
- MCAND  out  DATA_W  registered multiplicand, drives the array.
- MPLIER  out  DATA_W  registered multiplier, drives the array.
- BUSY  out  1  stall request to the PC/control unit.
- WB_VALID  out  1  write-enable to the register file, one-cycle pulse.
- WB_DATA  out  DATA_W  product to write.
- WB_ADDR  out  ADDR_W  register to write.
- OVERRUN  out  1  one-cycle pulse when a START is rejected.

## Operation
- States: IDLE, WAIT, WB. Encodings come from the shared package.
- IDLE, START=1:
  - Latch OPERAND1 into MCAND, OPERAND2 into MPLIER, and DEST_ADDR into an internal destination register.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, latch MULT_OUT into WB_DATA and the destination register into WB_ADDR, then go to WB.
- WB:
  - WB_VALID=1 for exactly this cycle.
  - START=1 is accepted here exactly as in IDLE and goes to WAIT, so back-to-back MULs lose no cycle.
  - Otherwise go to IDLE.
- START=1 in WAIT is ignored: no state, operand or destination change, and OVERRUN=1 the next cycle. The in-flight operation completes unchanged.
- MCAND and MPLIER hold their values after completion until the next accepted START.
- Arithmetic: the result is the low DATA_W bits of the product and is unsigned. There is no overflow flag.
- RESET:
  - All outputs and internal registers go to 0 and the state goes to IDLE.
  - Reset mid-WAIT discards the operation and no WB_VALID is produced.
  - RESET dominates a simultaneous START.

## Timing
- START sampled high at edge k (IDLE or WB): WAIT is entered at k, BUSY=1 after k.
- WB_DATA is captured at edge k+LATENCY, and WB_VALID=1 plus BUSY=0 follow in that same cycle.
- The register file writes at edge k+LATENCY+1.
- BUSY is registered. It is high exactly during WAIT, which lasts LATENCY cycles.
- LATENCY=1: WAIT lasts one cycle and WB_VALID appears at k+1.
- OVERRUN is registered, asserted the cycle after the rejected START.
- Reset values: MCAND=0, MPLIER=0, BUSY=0, WB_VALID=0, WB_DATA=0, WB_ADDR=0, OVERRUN=0.

## Structure
- Shared package `mult_pkg`:
  - state typedef (IDLE, WAIT, WB)
  - DATA_W and ADDR_W defaults
  - LATENCY default and its legal bounds
- One sub-module, `mult_lat_counter`: a loadable down-counter with load, enable and zero outputs, synchronous reset, 4 bits wide.
- The multiplier array is instantiated at the datapath level, not inside this block.

## Test plan
- 5×7 (0x05, 0x07), DEST_ADDR=3, LATENCY=2, START at edge k:
  - BUSY high for 2 cycles.
  - WB_VALID=1 with WB_DATA=0x23 and WB_ADDR=3 at k+2.
- Truncation, 16×17 (0x10, 0x11): WB_DATA=0x10, which is the low byte of 272.
- START again during WAIT with 0xFF, 0xFF:
  - OVERRUN pulses once.
  - MCAND and MPLIER unchanged.
  - First result still 0x23 to register 3.
  - No second WB.
- Back-to-back, second START in the WB cycle (2×3, then 4×4):
  - WB pulses 0x06 and then 0x10, LATENCY+1 cycles apart.
  - BUSY low only during the WB cycle.
- RESET one cycle into WAIT: all outputs 0, state IDLE, no WB_VALID in the following 5 cycles.
- LATENCY=1 build, 9×9: WB_DATA=0x51 one cycle after START, BUSY high for exactly 1 cycle.
